// File: rtl/seq_burst_checker_if.sv
// Bundle of signals between a sequence-generator test harness and the burst checker.
//   trig      : trigger shared with the generator's Xin
//   din       : generator serial output (Yout)
//   clr       : synchronous clear of both counters
//   busy      : a burst window is being checked
//   match     : one-cycle pulse, completed burst matched the pattern
//   mismatch  : one-cycle pulse, completed burst had at least one wrong bit
//   spurious  : one-cycle pulse, din was 1 while idle
//   match_cnt : saturating count of matched bursts
//   err_cnt   : saturating count of mismatch plus spurious events
// master drives the stimulus side; slave is the checker.
interface seq_burst_checker_if #(
    parameter int unsigned CNT_W = 8
) ();
    logic             trig;
    logic             din;
    logic             clr;
    logic             busy;
    logic             match;
    logic             mismatch;
    logic             spurious;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output trig,
        output din,
        output clr,
        input  busy,
        input  match,
        input  mismatch,
        input  spurious,
        input  match_cnt,
        input  err_cnt
    );

    modport slave (
        input  trig,
        input  din,
        input  clr,
        output busy,
        output match,
        output mismatch,
        output spurious,
        output match_cnt,
        output err_cnt
    );
endinterface

// File: rtl/seq_burst_checker.sv
// Serial checker sitting downstream of the 5-bit sequence generator.
// Follows the generator's timing from the shared trigger, checks each burst bit-for-bit
// against PATTERN (bit 0 first), flags 1s seen on the line while idle, and keeps
// saturating pass/error counters.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears all state and outputs
//   bus   : checker side of seq_burst_checker_if (trig/din/clr in, status out)
// All outputs are registered.
module seq_burst_checker #(
    parameter int unsigned CNT_W   = 8,
    parameter logic [4:0]  PATTERN = 5'b10100
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_burst_checker_if.slave    bus
);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StB1   = 3'd1,
        StB2   = 3'd2,
        StB3   = 3'd3,
        StB4   = 3'd4,
        StB5   = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             match_q, match_d;
    logic             mismatch_q, mismatch_d;
    logic             spurious_q, spurious_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             check_en;
    logic             exp_bit;
    logic             bit_bad;
    logic             fail_now;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; trig only matters in idle, mirroring the generator
    always_comb begin
        state_d = StIdle;
        case (state_q)
            StIdle:  state_d = bus.trig ? StB1 : StIdle;
            StB1:    state_d = StB2;
            StB2:    state_d = StB3;
            StB3:    state_d = StB4;
            StB4:    state_d = StB5;
            StB5:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Expected bit for the state being left on this edge
    always_comb begin
        check_en = 1'b0;
        exp_bit  = 1'b0;
        case (state_q)
            StB1: begin
                check_en = 1'b1;
                exp_bit  = PATTERN[0];
            end
            StB2: begin
                check_en = 1'b1;
                exp_bit  = PATTERN[1];
            end
            StB3: begin
                check_en = 1'b1;
                exp_bit  = PATTERN[2];
            end
            StB4: begin
                check_en = 1'b1;
                exp_bit  = PATTERN[3];
            end
            StB5: begin
                check_en = 1'b1;
                exp_bit  = PATTERN[4];
            end
            default: begin
                check_en = 1'b0;
                exp_bit  = 1'b0;
            end
        endcase
    end

    assign bit_bad  = check_en & (bus.din != exp_bit);
    // Final verdict folds in the last bit, which is compared on the B5 -> idle edge
    assign fail_now = err_q | bit_bad;

    // Output / datapath next-state logic
    always_comb begin
        err_d      = 1'b0;
        match_d    = 1'b0;
        mismatch_d = 1'b0;
        spurious_d = 1'b0;
        busy_d     = (state_d != StIdle);

        case (state_q)
            StIdle: begin
                // Error flag starts clean for the window entered from here
                err_d      = 1'b0;
                spurious_d = bus.din;
            end
            StB1, StB2, StB3, StB4: begin
                err_d = fail_now;
            end
            StB5: begin
                match_d    = ~fail_now;
                mismatch_d = fail_now;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase

        // Counters follow the registered pulses; clr wins over an increment
        match_cnt_d = match_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (bus.clr) begin
            match_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (match_q && !(&match_cnt_q)) begin
                match_cnt_d = match_cnt_q + CntOne;
            end
            if ((mismatch_q || spurious_q) && !(&err_cnt_q)) begin
                err_cnt_d = err_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            match_q     <= 1'b0;
            mismatch_q  <= 1'b0;
            spurious_q  <= 1'b0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_q       <= err_d;
            busy_q      <= busy_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            spurious_q  <= spurious_d;
            match_cnt_q <= match_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.match     = match_q;
    assign bus.mismatch  = mismatch_q;
    assign bus.spurious  = spurious_q;
    assign bus.match_cnt = match_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/seq_burst_checker.md
Name: seq_burst_checker

Overview:
- Serial checker placed directly downstream of the sequence generator; consumes its serial output and the same trigger that starts it.
- The generator answers a trigger accepted in idle with a 5-cycle burst, bits 0,0,1,0,1 (first bit first), then returns to idle, where it drives 0.
- This block tracks the generator's timing independently, checks every burst bit-for-bit and flags 1s seen on the line while idle.
- It keeps saturating pass/error counters for the self-test status path.

Parameters:
- CNT_W, 8, width of match_cnt and err_cnt.
- PATTERN, 5'b10100, expected burst; bit 0 is checked first, which gives the sequence 0,0,1,0,1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- trig  input  1  same trigger signal that drives the generator's Xin.
- din  input  1  generator serial output (Yout).
- clr  input  1  synchronous clear of both counters.
- busy  output  1  high while a burst window is being checked.
- match  output  1  one-cycle pulse: the burst just completed matched PATTERN.
- mismatch  output  1  one-cycle pulse: the burst just completed had at least one wrong bit.
- spurious  output  1  one-cycle pulse: din was 1 while idle.
- match_cnt  output  CNT_W  saturating count of matched bursts.
- err_cnt  output  CNT_W  saturating count of mismatch plus spurious events.

Behaviour:
- Reset values: state IDLE, busy=0, match=0, mismatch=0, spurious=0, match_cnt=0, err_cnt=0.
- Reset mid-window abandons the window; no pulse is produced for it.
- States: IDLE, B1, B2, B3, B4, B5, held in a 3-bit encoded register.
  - IDLE: on an edge with trig=1, go to B1; otherwise stay in IDLE.
  - B1 to B4: advance unconditionally to the next state.
  - B5: return to IDLE.
  - trig is ignored in every state except IDLE. This matches the generator, which samples its trigger only in idle.
  - Earliest retrigger is the edge after the B5 to IDLE edge.
  - Unused encodings go to IDLE on the next edge with no pulses.
- Bit check: on the edge leaving state Bn, din is compared with PATTERN[n-1].
  - A 1-bit error flag is cleared on entry to B1 and set on any compare mismatch.
  - On the B5 to IDLE edge, the final bit's compare is included: match is registered high if no compare failed, mismatch otherwise.
  - Each pulse lasts exactly one cycle.
- Latency: trig sampled at edge k; din is checked at edges k+1 through k+5; the match or mismatch pulse is high from edge k+5 to edge k+6.
- busy = 1 in states B1 to B5; it is a registered state decode.
- Spurious detection: on any edge where the state is IDLE and din=1, spurious is registered high for one cycle.
  - This applies even if trig=1 on the same edge. The window still starts in that case.
  - spurious and mismatch can never assert in the same cycle, because they are decided on different edges.
- Counters:
  - match_cnt increments by 1 on each match pulse.
  - err_cnt increments by 1 on each mismatch or spurious pulse.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - The counters update on the edge after the pulse is registered, i.e. they are derived from the registered pulses.
- clr: synchronous; zeroes both counters on an edge and wins over a simultaneous increment. It does not affect the state machine or the pulses.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
- Reset, then trig=1 for one cycle at edge 1, then din = 0,0,1,0,1 at edges 2 to 6 -> busy high over edges 1 to 6; match=1 for one cycle after edge 6; match_cnt=1; err_cnt=0; no spurious.
- Same trigger, with din at edge 4 forced to 0 (burst 0,0,0,0,1) -> mismatch pulse after edge 6, no match, err_cnt=1. The window is not aborted early: busy stays high through B5.
- Idle with din=1 for 3 consecutive edges -> 3 spurious pulses; err_cnt=3; busy stays 0.
- trig held high continuously with the generator model in the loop -> windows start at edges 1, 7, 13 (a 6-cycle period); each produces match; match_cnt=3 after edge 19; trig during busy is ignored.
- CNT_W=2, five good bursts -> match_cnt reaches 3 and holds. Then clr=1 on the same edge as the sixth match_cnt increment (the edge after its match pulse) -> match_cnt=0.
- Assert reset during state B3 -> all outputs 0 immediately (asynchronous). After release, din=1 for one edge in idle -> spurious=1; no leftover match or mismatch pulse.
